// File: rtl/coffee_ctrl.sv
// Control FSM for the coffee-machine datapath: coin capture, accumulate, dispense, change, drain.
// Optional change-return state enabled by defining COFFEE_CTRL_CHANGE_EN.
module coffee_ctrl #(
  parameter int unsigned HOLD_CYCLES = 25_000_000
) (
  input  logic coffee_ctrl_clock,
  input  logic coffee_ctrl_rst_n,
  input  logic coffee_ctrl_coin_1,
  input  logic coffee_ctrl_coin_2,
  input  logic coffee_ctrl_less_3,
  input  logic coffee_ctrl_eql_3,
  input  logic coffee_ctrl_grt_3,
  output logic coffee_ctrl_sel_en,
  output logic coffee_ctrl_sel_sel,
  output logic coffee_ctrl_cnt_ld,
  output logic coffee_ctrl_cnt_en,
  output logic coffee_ctrl_cnt_ud,
  output logic coffee_ctrl_coffee_out,
  output logic coffee_ctrl_change_out,
  output logic coffee_ctrl_busy
);

  localparam int unsigned TW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_CHANGE,
    S_DISPENSE,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    coin_meta_q, coin_meta_d;
  logic [1:0]    coin_sync_q, coin_sync_d;
  logic [1:0]    coin_prev_q, coin_prev_d;
  logic [1:0]    coin_pulse_q, coin_pulse_d;
  logic          coin2_q, coin2_d;
  logic          over_q, over_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    drain_q, drain_d;
  logic          sel_en_q, sel_en_d;
  logic          sel_sel_q, sel_sel_d;
  logic          cnt_ld_q, cnt_ld_d;
  logic          cnt_en_q, cnt_en_d;
  logic          coffee_q, coffee_d;
  logic          busy_q, busy_d;
`ifdef COFFEE_CTRL_CHANGE_EN
  logic          change_q, change_d;
`endif

  always_comb begin
    coin_meta_d  = {coffee_ctrl_coin_2, coffee_ctrl_coin_1};
    coin_sync_d  = coin_meta_q;
    coin_prev_d  = coin_sync_q;
    coin_pulse_d = coin_sync_q & ~coin_prev_q;

    state_d = state_q;
    coin2_d = coin2_q;
    over_d  = over_q;
    timer_d = timer_q;
    drain_d = drain_q;

    case (state_q)
      S_IDLE: begin
        // simultaneous pulses on both coins reject the coin outright
        if (coin_pulse_q[0] ^ coin_pulse_q[1]) begin
          coin2_d = coin_pulse_q[1];
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_CHECK;
      S_CHECK: begin
        case ({coffee_ctrl_less_3, coffee_ctrl_eql_3, coffee_ctrl_grt_3})
          3'b010: begin
            state_d = S_DISPENSE;
            timer_d = HOLD_LAST;
            over_d  = 1'b0;
          end
          3'b001: begin
`ifdef COFFEE_CTRL_CHANGE_EN
            state_d = S_CHANGE;
            timer_d = HOLD_LAST;
            over_d  = 1'b0;
`else
            state_d = S_DISPENSE;
            timer_d = HOLD_LAST;
            over_d  = 1'b1;
`endif
          end
          default: state_d = S_IDLE;
        endcase
      end
`ifdef COFFEE_CTRL_CHANGE_EN
      S_CHANGE: begin
        if (timer_q == '0) begin
          state_d = S_DISPENSE;
          timer_d = HOLD_LAST;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`endif
      S_DISPENSE: begin
        if (timer_q == '0) begin
          state_d = S_DRAIN;
          // kept overpayment leaves one extra unit in the counter
          drain_d = over_q ? 2'd3 : 2'd2;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_IDLE;
        else               drain_d = drain_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // outputs decoded from the next state so they register alongside it
    sel_en_d  = (state_d == S_LOAD);
    sel_sel_d = (state_d == S_LOAD) & coin2_d;
    cnt_ld_d  = (state_d == S_LOAD);
    cnt_en_d  = (state_d == S_DRAIN) || ((state_d == S_CHANGE) && (state_q != S_CHANGE));
    coffee_d  = (state_d == S_DISPENSE);
    busy_d    = (state_d != S_IDLE);
`ifdef COFFEE_CTRL_CHANGE_EN
    change_d  = (state_d == S_CHANGE);
`endif
  end

  always_ff @(posedge coffee_ctrl_clock or negedge coffee_ctrl_rst_n) begin
    if (!coffee_ctrl_rst_n) begin
      state_q      <= S_IDLE;
      coin_meta_q  <= '0;
      coin_sync_q  <= '0;
      coin_prev_q  <= '0;
      coin_pulse_q <= '0;
      coin2_q      <= 1'b0;
      over_q       <= 1'b0;
      timer_q      <= '0;
      drain_q      <= '0;
      sel_en_q     <= 1'b0;
      sel_sel_q    <= 1'b0;
      cnt_ld_q     <= 1'b0;
      cnt_en_q     <= 1'b0;
      coffee_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef COFFEE_CTRL_CHANGE_EN
      change_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      coin_meta_q  <= coin_meta_d;
      coin_sync_q  <= coin_sync_d;
      coin_prev_q  <= coin_prev_d;
      coin_pulse_q <= coin_pulse_d;
      coin2_q      <= coin2_d;
      over_q       <= over_d;
      timer_q      <= timer_d;
      drain_q      <= drain_d;
      sel_en_q     <= sel_en_d;
      sel_sel_q    <= sel_sel_d;
      cnt_ld_q     <= cnt_ld_d;
      cnt_en_q     <= cnt_en_d;
      coffee_q     <= coffee_d;
      busy_q       <= busy_d;
`ifdef COFFEE_CTRL_CHANGE_EN
      change_q     <= change_d;
`endif
    end
  end

  assign coffee_ctrl_sel_en     = sel_en_q;
  assign coffee_ctrl_sel_sel    = sel_sel_q;
  assign coffee_ctrl_cnt_ld     = cnt_ld_q;
  assign coffee_ctrl_cnt_en     = cnt_en_q;
  assign coffee_ctrl_cnt_ud     = 1'b0;
  assign coffee_ctrl_coffee_out = coffee_q;
  assign coffee_ctrl_busy       = busy_q;
`ifdef COFFEE_CTRL_CHANGE_EN
  assign coffee_ctrl_change_out = change_q;
`else
  assign coffee_ctrl_change_out = 1'b0;
`endif

endmodule

// File: tb/tb_coffee_ctrl.sv
// Scoreboard bench for coffee_ctrl with a behavioural datapath and a credit-level reference model.
module tb_coffee_ctrl;

  localparam int K_LOAD = 0, K_CHG = 1, K_COF = 2, K_IDLE = 3;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic clk = 1'b0, rst_n = 1'b0, coin1 = 1'b0, coin2 = 1'b0;
  logic less3, eql3, grt3;
  logic sel_en, sel_sel, cnt_ld, cnt_en, cnt_ud, coffee, change, busy;
  logic [2:0] cnt;

  int   errors = 0, checks = 0, cyc = 0, credit = 0;
  ev_t  exp_q[$];

  coffee_ctrl #(.HOLD_CYCLES(4)) dut (
    .coffee_ctrl_clock(clk), .coffee_ctrl_rst_n(rst_n),
    .coffee_ctrl_coin_1(coin1), .coffee_ctrl_coin_2(coin2),
    .coffee_ctrl_less_3(less3), .coffee_ctrl_eql_3(eql3), .coffee_ctrl_grt_3(grt3),
    .coffee_ctrl_sel_en(sel_en), .coffee_ctrl_sel_sel(sel_sel),
    .coffee_ctrl_cnt_ld(cnt_ld), .coffee_ctrl_cnt_en(cnt_en), .coffee_ctrl_cnt_ud(cnt_ud),
    .coffee_ctrl_coffee_out(coffee), .coffee_ctrl_change_out(change),
    .coffee_ctrl_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // datapath: selector + adder + up/down counter with compare-to-3 flags
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (cnt_ld) cnt <= cnt + (sel_en ? (sel_sel ? 3'd2 : 3'd1) : 3'd0);
    else if (cnt_en) cnt <= cnt_ud ? cnt + 3'd1 : cnt - 3'd1;
  end
  assign less3 = (cnt < 3'd3);
  assign eql3  = (cnt == 3'd3);
  assign grt3  = (cnt > 3'd3);

  function automatic void push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // reference model: credit accumulates per accepted coin; reaching 3+ buys one coffee
  function automatic void model_coin(input int value, input int pcyc);
    credit += value;
    push(K_LOAD, (pcyc + 4) * 4 + 2 + (value == 2 ? 1 : 0));
    if (credit < 3) begin
      push(K_IDLE, credit);
    end else if (credit == 3) begin
      push(K_COF, 4);
      push(K_IDLE, 30);
      credit = 0;
    end else begin
`ifdef COFFEE_CTRL_CHANGE_EN
      push(K_CHG, 4);
      push(K_COF, 104);
      push(K_IDLE, 30);
`else
      push(K_COF, 4);
      push(K_IDLE, 40);
`endif
      credit = 0;
    end
  endfunction

  task automatic emit(input int k, input int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d got=%0d expected none", k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        errors++;
        $display("FAIL event got kind=%0d val=%0d expected kind=%0d val=%0d", k, v, e.kind, e.val);
      end
    end
  endtask

  // monitor: turns DUT activity into events and compares against the scoreboard
  int chg_len, cof_len, drain_n;
  bit prev_busy, prev_change, prev_coffee, after_chg;
  always @(negedge clk) begin
    if (!rst_n) begin
      chg_len = 0; cof_len = 0; drain_n = 0;
      prev_busy = 0; prev_change = 0; prev_coffee = 0; after_chg = 0;
    end else begin
      checks++;
      if ((cnt_ld && cnt_en) || cnt_ud || (coffee && change)) begin
        errors++;
        $display("FAIL invariant ld=%b en=%b ud=%b coffee=%b change=%b required exclusive/ud=0",
                 cnt_ld, cnt_en, cnt_ud, coffee, change);
      end
      if (cnt_ld) emit(K_LOAD, cyc * 4 + (sel_en ? 2 : 0) + (sel_sel ? 1 : 0));
      if (change) chg_len++;
      else if (prev_change) begin emit(K_CHG, chg_len); chg_len = 0; end
      if (coffee && !prev_coffee) after_chg = prev_change;
      if (coffee) cof_len++;
      else if (prev_coffee) begin emit(K_COF, cof_len + (after_chg ? 100 : 0)); cof_len = 0; end
      if (cnt_en && !change) drain_n++;
      if (!busy && prev_busy) begin emit(K_IDLE, drain_n * 10 + int'(cnt)); drain_n = 0; end
      prev_busy = busy; prev_change = change; prev_coffee = coffee;
    end
  end

  task automatic press(input bit c1, input bit c2, input int hold, input bit accept);
    @(negedge clk);
    coin1 = c1;
    coin2 = c2;
    if (accept && (c1 ^ c2)) model_coin(c2 ? 2 : 1, cyc);
    repeat (hold) @(negedge clk);
    coin1 = 1'b0;
    coin2 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    repeat (6) @(negedge clk);
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout busy=%b required 0", busy);
    end
    checks++;
    if (int'(cnt) != credit) begin
      errors++;
      $display("FAIL counter got=%0d expected=%0d", cnt, credit);
    end
  endtask

  task automatic wait_coffee();
    int n;
    n = 0;
    while (!coffee && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!coffee) begin
      errors++;
      $display("FAIL coffee_timeout coffee=%b required 1", coffee);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [8:0] v;
    v = {sel_en, sel_sel, cnt_ld, cnt_en, cnt_ud, coffee, change, busy, |cnt};
    checks++;
    if (v != '0) begin
      errors++;
      $display("FAIL %s outputs+cnt got=%b required=000000000", name, v);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d required completion", cyc);
    $fatal(1);
  end

  initial begin
    #1 check_reset_outputs("reset_state");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // three 1-unit coins spaced apart
    for (int i = 0; i < 3; i++) begin
      press(1, 0, 2, 1);
      wait_idle();
      repeat (4) @(negedge clk);
    end

    // 2 then 1
    press(0, 1, 1, 1); wait_idle();
    press(1, 0, 1, 1); wait_idle();

    // 2 + 2 overpayment
    press(0, 1, 3, 1); wait_idle();
    press(0, 1, 3, 1); wait_idle();

    // coin during dispense is discarded; both coins together rejected in idle
    press(1, 0, 1, 1); wait_idle();
    press(1, 0, 1, 1); wait_idle();
    press(1, 0, 1, 1);
    wait_coffee();
    press(1, 0, 1, 0);
    wait_idle();
    press(1, 1, 2, 0); wait_idle();

    // button held for 100 cycles loads once
    press(1, 0, 100, 1); wait_idle();
    press(0, 1, 2, 1); wait_idle();

    // reset during the second dispense cycle
    press(1, 0, 1, 1); wait_idle();
    press(1, 0, 1, 1); wait_idle();
    press(1, 0, 1, 1);
    wait_coffee();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    exp_q.delete();
    credit = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      press(1, 0, 1, 1);
      wait_idle();
    end

    // randomized coin sequence
    for (int i = 0; i < 40; i++) begin
      int r;
      int h;
      r = int'($urandom_range(0, 9));
      h = int'($urandom_range(1, 4));
      if (r == 0)      press(1, 1, h, 0);
      else if (r < 6)  press(1, 0, h, 1);
      else             press(0, 1, h, 1);
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coffee_ctrl.md
# coffee_ctrl

Control FSM for the coffee-machine datapath. Takes the customer's coin buttons, steers the datapath's selector/adder/counter to accumulate the inserted value, and reads the datapath's compare-to-3 flags. It then drives the dispense and change indicators and returns the counter to zero. Sits directly upstream of the datapath: its control outputs feed the datapath's sel/cnt inputs, and the datapath's Less_3/Eql_3/Grt_3 flags feed back into it.

## Interface
- HOLD_CYCLES, default 25_000_000: on-time of coffee_out and change_out pulses (0.5 s at 50 MHz); benches override to 4. Minimum 1.
- coffee_ctrl_clock, input, 1: system clock, rising edge.
- coffee_ctrl_rst_n, input, 1: asynchronous, active-low reset; also resets the datapath counter.
- coffee_ctrl_coin_1, input, 1: 1-unit coin button, level, asynchronous to clock.
- coffee_ctrl_coin_2, input, 1: 2-unit coin button, level, asynchronous to clock.
- coffee_ctrl_less_3 / _eql_3 / _grt_3, input, 1 each: datapath comparator flags (counter <, =, > 3), combinational from the counter.
- coffee_ctrl_sel_en, output, 1: selector enable (0 → selector outputs 0).
- coffee_ctrl_sel_sel, output, 1: 0 selects value 1, 1 selects value 2.
- coffee_ctrl_cnt_ld, output, 1: counter loads selector+counter sum.
- coffee_ctrl_cnt_en, output, 1: counter step enable.
- coffee_ctrl_cnt_ud, output, 1: step direction; 0 = down. Always 0 in this block.
- coffee_ctrl_coffee_out, output, 1: dispense indicator.
- coffee_ctrl_change_out, output, 1: 1-unit change-return indicator.
- coffee_ctrl_busy, output, 1: high in every state except IDLE.

## Operation
- Each coin input passes through a 2-FF synchronizer and a rising-edge detector, giving a one-cycle pulse.
- A button held high gives exactly one pulse.
- Both pulses in the same cycle: the coin is rejected. No load occurs and the state stays IDLE.
- All outputs are Moore-decoded from registered state. cnt_ld and cnt_en are never high together.
- States:
  - IDLE: all outputs 0. A single coin pulse latches the coin type into coin_is_2 → LOAD.
  - LOAD (1 cycle): sel_en=1, sel_sel=coin_is_2, cnt_ld=1 → CHECK.
  - CHECK (1 cycle): flags reflect the new counter value.
    - less_3 → IDLE.
    - eql_3 → DISPENSE.
    - grt_3 → CHANGE.
  - CHANGE (HOLD_CYCLES): change_out=1; cnt_en=1 on the first cycle only (4 → 3) → DISPENSE.
  - DISPENSE (HOLD_CYCLES): coffee_out=1 → DRAIN.
  - DRAIN: cnt_en=1 for exactly drain_n cycles, bringing the counter to 0 → IDLE.
    - drain_n = 3 normally.
    - drain_n = 4 in the no-change configuration when CHECK saw grt_3.
- Reachable counter values: 0–4. The maximum, 4, comes from 2 + 2. Counter never wraps.
- Coin pulses outside IDLE are discarded, not queued.
- Flag combination not exactly one-hot in CHECK (datapath fault) → IDLE. No load, no output.
- Hold timer width is $clog2(HOLD_CYCLES+1). The timer reloads on every entry to CHANGE or DISPENSE.

## Timing
- Reset (async assert, sync release): state IDLE, synchronizers/edge regs/timer/drain count/coin_is_2 cleared. All outputs 0.
- Coin rising before clock edge k: pulse high in the cycle after edge k+2. LOAD occupies the cycle after edge k+3; counter updates at edge k+4; CHECK occupies cycle k+4.
- Exact payment: coffee_out rises at the edge after CHECK and stays high HOLD_CYCLES cycles. DRAIN follows for 3 cycles. busy falls at the edge after the last DRAIN cycle.
- Overpayment: change_out is high HOLD_CYCLES cycles, then coffee_out is high HOLD_CYCLES cycles, back to back. No overlap.
- Reset mid-operation: everything returns to reset values immediately. Datapath counter is cleared by the same reset, so no drain is needed.

## Configuration
- COFFEE_CTRL_CHANGE_EN defined: the CHANGE state exists and grt_3 → CHANGE.
- Undefined:
  - No CHANGE state; change_out is tied 0.
  - grt_3 → DISPENSE; overpayment is kept.
  - DRAIN runs 4 cycles after a grt_3 entry, 3 otherwise.

## Test plan
- Three coin_1 presses spaced 10 cycles apart (HOLD_CYCLES=4) → two LOAD/CHECK→IDLE passes, third → coffee_out high 4 cycles. Counter ends at 0; busy then 0.
- coin_2 then coin_1 → counter 2 then 3. Exactly one coffee_out pulse of 4 cycles; change_out stays 0.
- Two coin_2 presses, macro defined → counter 4, change_out 4 cycles (counter → 3), then coffee_out 4 cycles, counter → 0. Macro undefined → no change_out, coffee_out 4 cycles, 4 DRAIN cycles, counter 0.
- coin_1 pressed during DISPENSE and coin_1+coin_2 rising in the same cycle in IDLE → no cnt_ld, counter unchanged.
- Button held high 100 cycles → exactly one LOAD.
- rst_n low in the 2nd DISPENSE cycle → coffee_out, busy and all control outputs 0 immediately. Counter 0. Next three coin_1 presses dispense normally.
